// File: rtl/div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// div_unit : iterative radix-2 restoring divider, signed/unsigned, en/done  (rev 1.0)
// ============================================================================
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             is_flush,
   input  logic             en,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             done
);

   localparam int              c_CW   = $clog2(WIDTH);
   localparam logic [1:0]      c_IDLE = 2'd0;
   localparam logic [1:0]      c_CALC = 2'd1;
   localparam logic [1:0]      c_DONE = 2'd2;
   localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
   localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

   logic [1:0]       r_state;
   logic [c_CW-1:0]  r_cnt;
   logic [WIDTH-1:0] r_rem;
   logic [WIDTH-1:0] r_dvd;
   logic [WIDTH-1:0] r_dsr;
   logic             r_q_neg;
   logic             r_r_neg;

   logic [WIDTH-1:0] w_a_mag;
   logic [WIDTH-1:0] w_b_mag;
   logic [WIDTH:0]   w_shift;
   logic [WIDTH:0]   w_diff;
   logic             w_fits;
   logic [WIDTH-1:0] w_rem_nxt;
   logic [WIDTH-1:0] w_quo_nxt;
   logic [WIDTH-1:0] w_rem_fix;
   logic [WIDTH-1:0] w_quo_fix;

   assign w_a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
   assign w_b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

   // The dividend shifts out of r_dvd while quotient bits shift in behind it.
   assign w_shift   = {r_rem, r_dvd[WIDTH-1]};
   assign w_diff    = w_shift - {1'b0, r_dsr};
   assign w_fits    = ~w_diff[WIDTH];
   assign w_rem_nxt = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
   assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_fits};
   assign w_quo_fix = r_q_neg ? -w_quo_nxt : w_quo_nxt;
   assign w_rem_fix = r_r_neg ? -w_rem_nxt : w_rem_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= c_IDLE;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_dvd     <= '0;
         r_dsr     <= '0;
         r_q_neg   <= 1'b0;
         r_r_neg   <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (is_flush) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               c_IDLE: begin
                  if (en) begin
                     r_rem   <= '0;
                     r_dvd   <= w_a_mag;
                     r_dsr   <= w_b_mag;
                     r_q_neg <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                     r_r_neg <= is_signed & a[WIDTH-1];
                     r_cnt   <= '0;
                     // Divide by zero completes immediately with the raw dividend.
                     if (b == '0) begin
                        quotient  <= '1;
                        remainder <= a;
                        done      <= 1'b1;
                        r_state   <= c_DONE;
                     end else begin
                        r_state <= c_CALC;
                     end
                  end
               end
               c_CALC: begin
                  r_rem <= w_rem_nxt;
                  r_dvd <= w_quo_nxt;
                  if (r_cnt == c_LAST) begin
                     quotient  <= w_quo_fix;
                     remainder <= w_rem_fix;
                     done      <= 1'b1;
                     r_cnt     <= '0;
                     r_state   <= c_DONE;
                  end else begin
                     r_cnt <= r_cnt + c_ONE;
                  end
               end
               c_DONE:  r_state <= c_IDLE;
               default: r_state <= c_IDLE;
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_div_unit : scoreboard bench for div_unit (directed + random)  (rev 1.0)
// ============================================================================
module tb_div_unit;

   localparam int W = 32;

   typedef struct {
      logic [W-1:0] q;
      logic [W-1:0] r;
      int           due;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         is_flush;
   logic         en;
   logic         is_signed;
   logic [W-1:0] a_in;
   logic [W-1:0] b_in;
   logic [W-1:0] quo;
   logic [W-1:0] rem;
   logic         done;

   int   n_tests  = 0;
   int   n_fail   = 0;
   int   edge_cnt = 0;
   exp_t sb[$];

   div_unit #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .is_flush  (is_flush),
      .en        (en),
      .is_signed (is_signed),
      .a         (a_in),
      .b         (b_in),
      .quotient  (quo),
      .remainder (rem),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input logic s, input int due);
      exp_t   m;
      longint sx, sy, qq, rr;
      m.due = due;
      if (y == '0) begin
         m.q = '1;
         m.r = x;
      end else if (s) begin
         sx  = longint'($signed(x));
         sy  = longint'($signed(y));
         qq  = sx / sy;
         rr  = sx % sy;
         m.q = qq[W-1:0];
         m.r = rr[W-1:0];
      end else begin
         m.q = x / y;
         m.r = x % y;
      end
      return m;
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard whenever done is presented.
   initial begin
      logic prev_done;
      int   cyc;
      exp_t e;
      prev_done = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc = edge_cnt + 1;
         if (done) begin
            chk("done_single_pulse", {31'd0, prev_done}, '0);
            if (sb.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_done: got done=1 in cycle %0d expected no result", cyc);
            end else begin
               e = sb.pop_front();
               chk("quotient", quo, e.q);
               chk("remainder", rem, e.r);
               chk("done_cycle", 32'(cyc), 32'(e.due));
            end
         end
         prev_done = done;
      end
   end

   task automatic drive_start(input logic [W-1:0] ta, input logic [W-1:0] tb,
                              input logic ts, input bit expect_it);
      int n;
      @(negedge clk);
      is_flush  = 1'b0;
      en        = 1'b1;
      a_in      = ta;
      b_in      = tb;
      is_signed = ts;
      n = edge_cnt + 1;
      if (expect_it) sb.push_back(model(ta, tb, ts, n + ((tb == '0) ? 1 : W + 1)));
   endtask

   task automatic wait_idle(input int bound);
      int k;
      k = 0;
      while (sb.size() != 0 && k < bound) begin
         @(negedge clk);
         k++;
      end
      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL timeout: got %0d results pending after %0d cycles expected 0", sb.size(), bound);
         sb.delete();
      end
   endtask

   // Operands are scrambled after the start to show they were latched.
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts);
      drive_start(ta, tb, ts, 1'b1);
      @(negedge clk);
      en        = 1'b0;
      a_in      = $urandom;
      b_in      = $urandom;
      is_signed = 1'($urandom);
      wait_idle(W + 10);
   endtask

   initial begin
      logic [W-1:0] da[8] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'h8000_0000,
                              32'hFFFF_FFFF, 32'd5, 32'd5, 32'h8000_0000};
      logic [W-1:0] db[8] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF};
      logic         ds[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [W-1:0] ra, rb;

      rst_n = 1'b0; is_flush = 1'b0; en = 1'b0; is_signed = 1'b0;
      a_in = '0; b_in = '0;
      repeat (3) @(negedge clk);
      chk("reset_done", {31'd0, done}, '0);
      chk("reset_quotient", quo, '0);
      chk("reset_remainder", rem, '0);
      rst_n = 1'b1;

      for (int i = 0; i < 8; i++) run_op(da[i], db[i], ds[i]);

      // Flush mid-CALC, then a fresh divide right after.
      drive_start(32'd100, 32'd7, 1'b0, 1'b0);
      @(negedge clk);
      en = 1'b0;
      repeat (9) @(negedge clk);
      is_flush = 1'b1;
      drive_start(32'd9, 32'd3, 1'b0, 1'b1);
      @(negedge clk);
      en = 1'b0;
      wait_idle(W + 10);

      // Flush together with en in IDLE must not start anything.
      @(negedge clk);
      en = 1'b1; is_flush = 1'b1; a_in = 32'd9; b_in = 32'd0;
      @(negedge clk);
      en = 1'b0; is_flush = 1'b0;
      repeat (40) @(negedge clk);
      chk("hold_quotient", quo, 32'd3);
      chk("hold_remainder", rem, 32'd0);

      // Back-to-back with en held across the DONE cycle.
      drive_start(32'd100, 32'd7, 1'b0, 1'b1);
      repeat (W + 1) @(negedge clk);
      a_in = 32'd50; b_in = 32'd6;
      sb.push_back(model(32'd50, 32'd6, 1'b0, edge_cnt + 2 + W + 1));
      @(negedge clk);
      @(negedge clk);
      en = 1'b0;
      wait_idle(W + 10);

      // Flush in the DONE cycle keeps the completed result.
      drive_start(32'd1000, 32'd10, 1'b0, 1'b1);
      @(negedge clk);
      en = 1'b0;
      repeat (W) @(negedge clk);
      is_flush = 1'b1;
      @(negedge clk);
      is_flush = 1'b0;
      chk("flush_done_quotient", quo, 32'd100);
      chk("flush_done_remainder", rem, 32'd0);

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         case ($urandom_range(0, 7))
            0:       rb = '0;
            1, 2:    rb = 32'($urandom_range(1, 15));
            3:       rb = 32'hFFFF_FFFF;
            default: rb = $urandom;
         endcase
         if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
         run_op(ra, rb, 1'($urandom));
      end

      // Reset in the middle of an operation discards it.
      run_op(32'd100, 32'd7, 1'b0);
      drive_start(32'd100, 32'd7, 1'b0, 1'b0);
      @(negedge clk);
      en = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_done", {31'd0, done}, '0);
      chk("midreset_quotient", quo, '0);
      chk("midreset_remainder", rem, '0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider that answers the Execute stage's multicycle en/done handshake, the same handshake the multiplier uses.
- Execute holds en = is_div && !done and stalls while !done.
- The unit latches operands on start, computes quotient and remainder over WIDTH cycles, and pulses done for exactly one cycle.
- Supports signed (div.w/mod.w) and unsigned (div.wu/mod.wu) operation. The pipeline flush aborts it.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH; counter is $clog2(WIDTH) bits

Ports:
clk  input  1  clock; all state on rising edge
rst_n  input  1  reset, asynchronous, active-low
is_flush  input  1  abort current operation; highest priority
en  input  1  start request; sampled only in IDLE
is_signed  input  1  1 = two's-complement operands; sampled with en
a  input  WIDTH  dividend; sampled with en
b  input  WIDTH  divisor; sampled with en
quotient  output  WIDTH  quotient, registered
remainder  output  WIDTH  remainder, registered
done  output  1  result valid; one-cycle pulse, registered

Behaviour:
- Reset (async, rst_n=0): state=IDLE, done=0, quotient=0, remainder=0, counter=0. A reset in the middle of an operation discards it.
- States: IDLE, CALC, DONE.
  - IDLE: if en && !is_flush, latch the following, then go to CALC (or straight to DONE when b==0):
    - magnitudes |a| and |b| (negated only if is_signed and MSB set);
    - sign flags q_neg = is_signed & (a[MSB]^b[MSB]) and r_neg = is_signed & a[MSB];
    - the raw value of a.
  - CALC: one restoring step per cycle on the {partial remainder, dividend shift} register. Counter runs 0..WIDTH-1. After step WIDTH-1, go to DONE and load the quotient/remainder output registers with sign-corrected values.
  - DONE: done=1 for this single cycle; next state is IDLE unconditionally.
- Latency: en first sampled high in IDLE in cycle N gives done=1 in cycle N+WIDTH+1 (N+33 for WIDTH=32). b==0 gives done=1 in cycle N+1.
- Divide-by-zero result: quotient = all ones, remainder = raw a, independent of is_signed.
- Sign rules:
  - Quotient truncates toward zero; it is negated iff q_neg.
  - Remainder takes the sign of the dividend; it is negated iff r_neg.
  - Overflow case a=0x80000000, b=0xFFFFFFFF signed gives quotient=0x80000000, remainder=0 (natural result of magnitude arithmetic, no special case).
- Output registers change only on entry to DONE. They hold their value through IDLE until the next completion.
- Handshake:
  - en is ignored outside IDLE; operands are latched, so forwarding changes on a/b during CALC have no effect.
  - en deasserting mid-CALC without flush does not abort.
  - If en is still high in the DONE cycle, it is not a new start: DONE always returns to IDLE first. A back-to-back divide starts when en is sampled in IDLE the following cycle.
- Flush: is_flush=1 in any state forces next state IDLE and clears the counter; done is not asserted afterwards.
  - Flush during DONE: done still reads 1 in that cycle (registered) and the consumer ignores it. Output registers keep the completed value.
  - Flush and en together in IDLE: no start.
- done is never high for two consecutive cycles.

Test Plan:
- Unsigned a=100, b=7, is_signed=0, en at cycle N -> done only in cycle N+33; quotient=14, remainder=2; done low in N+34.
- Signed a=0xFFFFFFF9 (-7), b=2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); also a=7, b=0xFFFFFFFE -> quotient=0xFFFFFFFD, remainder=1.
- Signed overflow a=0x80000000, b=0xFFFFFFFF -> quotient=0x80000000, remainder=0. Unsigned a=0xFFFFFFFF, b=1 -> quotient=0xFFFFFFFF, remainder=0.
- Divide by zero a=5, b=0 (both is_signed values) -> done in cycle N+1, quotient=0xFFFFFFFF, remainder=5.
- Abort and recovery:
  - Start 100/7, is_flush pulse in cycle N+10 -> no done; unit in IDLE in N+11. New en (9/3) in N+11 -> done in N+44, quotient=3, remainder=0.
  - Same start with rst_n low mid-CALC -> done=0, quotient=remainder=0 immediately.
- Back-to-back: en held high across the DONE cycle with new operands 50/6 -> first done at N+33, second start sampled at N+34, second done at N+67 with quotient=8, remainder=2; no double done pulse.
